audio_codec_slave_port: RTL and testbench
=========================================

// Module: audio_codec_slave_port
// PURPOSE
//  Codec-side (slave) end of the 16-bit WM8731/TLV320AIC23 serial audio link; the FPGA-side serializer is the master.
//  Takes BCLK, LRC and DIN from the master and deserializes each frame into DAC sample pairs.
//  Serializes ADC sample pairs onto DOUT in the same frame.
//  Used as an on-chip codec emulator for loopback/bring-up, or where the FPGA is slave to an external master.
// PARAMETERS
//  DATA_W   16  bits per channel; one frame = 2*DATA_W bits, left channel first, MSB first
//  SYNC_N   2   synchronizer flops on bclk/lrc/din (>=2)
// PORTS
//  clk             in   1       system clock; must be >= 12x BCLK frequency
//  reset           in   1       asynchronous, active-high reset
//  bclk            in   1       serial bit clock from master (asynchronous to clk)
//  lrc             in   1       frame/channel strobe from master: high = left channel for DATA_W bits, then low
//  din             in   1       serial DAC data from master
//  dout            out  1       serial ADC data to master
//  dac_data_l      out  DATA_W  last complete received left sample
//  dac_data_r      out  DATA_W  last complete received right sample
//  dac_data_valid  out  1       1-clk pulse when dac_data_l/r update
//  adc_data_l      in   DATA_W  left sample to transmit
//  adc_data_r      in   DATA_W  right sample to transmit
//  adc_load        in   1       1-clk strobe; captures adc_data_l/r into the tx holding register
//  adc_req         out  1       1-clk pulse at frame start; holding register consumed, load the next pair
//  frame_err       out  1       1-clk pulse on LRC protocol violation
//  loopback        in   1       present only with AUDIO_SLAVE_LOOPBACK_EN
// BEHAVIOUR
//  - Reset values:
//    - outputs: dout=0; dac_data_l/r=0; dac_data_valid=0; adc_req=0; frame_err=0.
//    - internal: hold=0; state=IDLE; bit counter=0.
//    - Reset mid-frame aborts the frame with no partial update.
//  - Input synchronization: bclk, lrc, din each pass through SYNC_N flops.
//    - An extra bclk stage yields bclk_rise/bclk_fall 1-clk pulses.
//  - Sampling: lrc and din are sampled only on bclk_fall (master changes them on BCLK rising).
//    - lrc_last holds the lrc value from the previous bclk_fall.
//  - FSM (bit counter k = 0..2*DATA_W-1):
//    - IDLE: dout = hold MSB continuously, tx_shift = hold.
//      - On bclk_fall with lrc=1 and lrc_last=0: frame start; bit 0 captured (L MSB).
//      - Pulse adc_req; go to LEFT with k=1.
//    - LEFT: each bclk_fall captures din, k++.
//      - Expected lrc=1 for k<DATA_W and lrc=0 at k=DATA_W; at k=DATA_W go to RIGHT.
//    - RIGHT: each bclk_fall captures din with expected lrc=0, k++.
//      - After bit 2*DATA_W-1 go to IDLE and latch rx_shift into dac_data_l (upper half) and dac_data_r (lower half).
//      - dac_data_valid pulses the clk after the latch.
//  - Protocol check: lrc not as expected in LEFT/RIGHT -> frame_err pulse, frame discarded, dac outputs unchanged.
//    - If the violating sample is a new lrc rise (lrc=1, lrc_last=0), that same bclk_fall starts a new frame (adc_req pulses).
//    - Otherwise go to IDLE.
//  - TX: dout = tx_shift MSB.
//    - tx_shift left-shifts on each bclk_rise while in LEFT/RIGHT, so the master sees 2*DATA_W bits on its BCLK-falling samples.
//    - dout update <= 3 clk after the bclk edge; hence the clk >= 12x BCLK requirement.
//  - Hold register: adc_load writes hold at any time, taking effect at the next frame start.
//    - A frame in progress is never altered by adc_load.
//    - No adc_load since the last frame -> the same pair is resent (no error).
//    - adc_load in the same clk as frame start: the new pair is transmitted.
//  - bclk stopped mid-frame: state holds indefinitely; the next lrc rise seen while k!=expected raises frame_err and restarts.
// CONFIGURATION
//  - AUDIO_SLAVE_LOOPBACK_EN defined:
//    - loopback port exists.
//    - With loopback=1, each completed frame writes {dac_data_l,dac_data_r} into hold in the latch clk, overriding a simultaneous adc_load.
//    - The master therefore receives its own frame N during frame N+1.
//  - Not defined: no loopback port; hold is written only by adc_load.
// TESTING
//  1. Master frame L=16'hA5C3, R=16'h1234 -> dac_data_l=A5C3, dac_data_r=1234; one dac_data_valid pulse <=4 clk after the 32nd bclk_fall.
//  2. adc_load L=16'h8001, R=16'h7FFE before the frame -> master captures 32'h80017FFE; adc_req pulses once at frame start.
//  3. Two frames with no adc_load between -> second frame DOUT repeats 32'h80017FFE.
//  4. lrc drops after 8 left bits -> frame_err pulse; no dac_data_valid; dac_data_l/r keep A5C3/1234.
//  5. reset asserted at bit 20, then a clean frame L=16'h0F0F, R=16'hF0F0 -> outputs 0 during reset; then 0F0F/F0F0 with a single valid pulse.
//  6. (AUDIO_SLAVE_LOOPBACK_EN, loopback=1) frame 16'h1111/16'h2222, then any frame -> second frame DOUT = 32'h11112222.

Source files
------------

// File: rtl/audio_codec_slave_port.sv
// Codec-side slave end of a 16-bit I2S-style audio link: deserializes DAC frames from DIN, serializes ADC pairs onto DOUT.
// Optional feature macro: AUDIO_SLAVE_LOOPBACK_EN (adds loopback port; completed frames are written back into the tx holding register).
module audio_codec_slave_port #(
  parameter int DATA_W = 16,
  parameter int SYNC_N = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bclk,
  input  logic              lrc,
  input  logic              din,
  output logic              dout,
  output logic [DATA_W-1:0] dac_data_l,
  output logic [DATA_W-1:0] dac_data_r,
  output logic              dac_data_valid,
  input  logic [DATA_W-1:0] adc_data_l,
  input  logic [DATA_W-1:0] adc_data_r,
  input  logic              adc_load,
  output logic              adc_req,
  output logic              frame_err
`ifdef AUDIO_SLAVE_LOOPBACK_EN
  ,
  input  logic              loopback
`endif
);

  localparam int FW = 2 * DATA_W;
  localparam int KW = $clog2(FW);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t          state;
  logic [SYNC_N-1:0] bclk_sync, lrc_sync, din_sync;
  logic            bclk_d, lrc_last;
  logic [KW-1:0]   k;
  logic [FW-1:0]   rx_shift, tx_shift, hold;

  logic            bclk_s, lrc_s, din_s;
  logic            bclk_rise, bclk_fall, lrc_rise, lrc_expect;
  logic            proto_err, start, latch, lb_latch;
  logic [FW-1:0]   rx_next, adc_pair;

  always_comb begin
    bclk_s     = bclk_sync[SYNC_N-1];
    lrc_s      = lrc_sync[SYNC_N-1];
    din_s      = din_sync[SYNC_N-1];
    bclk_rise  = bclk_s & ~bclk_d;
    bclk_fall  = ~bclk_s & bclk_d;
    lrc_rise   = lrc_s & ~lrc_last;
    rx_next    = {rx_shift[FW-2:0], din_s};
    adc_pair   = {adc_data_l, adc_data_r};
    lrc_expect = (state == LEFT) ? (k < KW'(DATA_W)) : 1'b0;
    // A fresh lrc rise mid-frame is always a violation, even where lrc=1 is expected.
    proto_err  = bclk_fall && (state != IDLE) && ((lrc_s != lrc_expect) || lrc_rise);
    start      = bclk_fall && lrc_rise;
    latch      = bclk_fall && (state == RIGHT) && (k == KW'(FW - 1)) && !proto_err;
`ifdef AUDIO_SLAVE_LOOPBACK_EN
    lb_latch   = latch && loopback;
`else
    lb_latch   = 1'b0;
`endif
    dout       = tx_shift[FW-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync      <= '0;
      lrc_sync       <= '0;
      din_sync       <= '0;
      bclk_d         <= 1'b0;
      lrc_last       <= 1'b0;
      state          <= IDLE;
      k              <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      hold           <= '0;
      dac_data_l     <= '0;
      dac_data_r     <= '0;
      dac_data_valid <= 1'b0;
      adc_req        <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      bclk_sync      <= {bclk_sync[SYNC_N-2:0], bclk};
      lrc_sync       <= {lrc_sync[SYNC_N-2:0], lrc};
      din_sync       <= {din_sync[SYNC_N-2:0], din};
      bclk_d         <= bclk_s;
      dac_data_valid <= 1'b0;
      adc_req        <= 1'b0;
      frame_err      <= 1'b0;
      if (bclk_fall) lrc_last <= lrc_s;

      if (lb_latch) hold <= rx_next;
      else if (adc_load) hold <= adc_pair;

      if (start) begin
        // Restart also covers the mid-frame violation case; the new pair wins over hold.
        state     <= LEFT;
        k         <= KW'(1);
        rx_shift  <= rx_next;
        tx_shift  <= adc_load ? adc_pair : hold;
        adc_req   <= 1'b1;
        frame_err <= proto_err;
      end else if (proto_err) begin
        frame_err <= 1'b1;
        state     <= IDLE;
        k         <= '0;
      end else begin
        case (state)
          IDLE: tx_shift <= hold;
          LEFT: begin
            if (bclk_rise) tx_shift <= {tx_shift[FW-2:0], 1'b0};
            if (bclk_fall) begin
              rx_shift <= rx_next;
              k        <= k + KW'(1);
              if (k == KW'(DATA_W)) state <= RIGHT;
            end
          end
          RIGHT: begin
            if (bclk_rise) tx_shift <= {tx_shift[FW-2:0], 1'b0};
            if (latch) begin
              state          <= IDLE;
              k              <= '0;
              dac_data_l     <= rx_next[FW-1:DATA_W];
              dac_data_r     <= rx_next[DATA_W-1:0];
              dac_data_valid <= 1'b1;
            end else if (bclk_fall) begin
              rx_shift <= rx_next;
              k        <= k + KW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_codec_slave_port.sv
// Directed bench for audio_codec_slave_port: the bench acts as the serial master with BCLK = clk/16.
module tb_audio_codec_slave_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bclk = 1'b0, lrc = 1'b0, din = 1'b0;
  logic        dout;
  logic [15:0] dac_data_l, dac_data_r;
  logic        dac_data_valid;
  logic [15:0] adc_data_l = '0, adc_data_r = '0;
  logic        adc_load = 1'b0;
  logic        adc_req, frame_err;
  logic        loopback = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0, req_cnt = 0, err_cnt = 0;
  int valid_snap = 0;

  always #5 clk = ~clk;

  audio_codec_slave_port #(.DATA_W(16), .SYNC_N(2)) dut (
    .clk(clk), .reset(reset), .bclk(bclk), .lrc(lrc), .din(din), .dout(dout),
    .dac_data_l(dac_data_l), .dac_data_r(dac_data_r), .dac_data_valid(dac_data_valid),
    .adc_data_l(adc_data_l), .adc_data_r(adc_data_r), .adc_load(adc_load),
    .adc_req(adc_req), .frame_err(frame_err)
`ifdef AUDIO_SLAVE_LOOPBACK_EN
    , .loopback(loopback)
`endif
  );

  always @(posedge clk) begin
    if (dac_data_valid) valid_cnt++;
    if (adc_req) req_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_pair(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    adc_data_l = l; adc_data_r = r; adc_load = 1'b1;
    @(negedge clk);
    adc_load = 1'b0;
  endtask

  // One leading lrc=0 bit, then 32 bits; lrc forced low from bit err_at, adc_load pulsed during bit load_at,
  // reset asserted at bit abort_at (frame abandoned there).
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int err_at,
                            input int load_at, input logic [15:0] ll, input logic [15:0] lr,
                            input int abort_at, output logic [31:0] rx);
    logic [31:0] tx;
    tx = {l, r};
    rx = '0;
    @(negedge clk);
    bclk = 1'b1; lrc = 1'b0; din = 1'b0; #80;
    bclk = 1'b0; #80;
    for (int i = 0; i < 32; i++) begin
      bclk = 1'b1; lrc = (i < 16) && (i < err_at); din = tx[31-i];
      if (i == abort_at) begin
        reset = 1'b1;
        #20;
        return;
      end
      #40;
      if (i == load_at) begin
        adc_data_l = ll; adc_data_r = lr; adc_load = 1'b1; #10;
        adc_load = 1'b0; #30;
      end else #40;
      bclk = 1'b0;
      rx[31-i] = dout;
      if (i == 31) begin
        #40 valid_snap = valid_cnt;
        #40;
      end else #80;
    end
  endtask

  logic [31:0] rx;
  int v0, q0, e0;

  initial begin
    #33;
    check("rst_dout", {31'd0, dout}, 32'd0);
    check("rst_dac", {dac_data_l, dac_data_r}, 32'd0);
    check("rst_pulses", {29'd0, dac_data_valid, adc_req, frame_err}, 32'd0);
    reset = 1'b0;
    #40;

    // Test 1/2: loaded pair goes out, A5C3/1234 comes in
    load_pair(16'h8001, 16'h7FFE);
    v0 = valid_cnt; q0 = req_cnt; e0 = err_cnt;
    send_frame(16'hA5C3, 16'h1234, 99, 99, '0, '0, 99, rx);
    check("t1_valid_4clk", valid_snap - v0, 1);
    #200;
    check("t1_dac", {dac_data_l, dac_data_r}, 32'hA5C31234);
    check("t1_valid_once", valid_cnt - v0, 1);
    check("t2_dout", rx, 32'h80017FFE);
    check("t2_req", req_cnt - q0, 1);
    check("t1_no_err", err_cnt - e0, 0);

    // Test 3: no reload, same pair resent
    v0 = valid_cnt;
    send_frame(16'hA5C3, 16'h1234, 99, 99, '0, '0, 99, rx);
    #200;
    check("t3_dout_repeat", rx, 32'h80017FFE);
    check("t3_valid", valid_cnt - v0, 1);

    // Test 4: lrc drops after 8 left bits
    v0 = valid_cnt; q0 = req_cnt; e0 = err_cnt;
    send_frame(16'h5555, 16'hAAAA, 8, 99, '0, '0, 99, rx);
    #200;
    check("t4_err", err_cnt - e0, 1);
    check("t4_no_valid", valid_cnt - v0, 0);
    check("t4_dac_kept", {dac_data_l, dac_data_r}, 32'hA5C31234);
    check("t4_req", req_cnt - q0, 1);

    // Test 5: reset at bit 20, then a clean frame with a mid-frame load
    send_frame(16'h9999, 16'h6666, 99, 99, '0, '0, 20, rx);
    check("t5_dac_in_rst", {dac_data_l, dac_data_r}, 32'd0);
    check("t5_dout_in_rst", {31'd0, dout}, 32'd0);
    check("t5_valid_in_rst", {31'd0, dac_data_valid}, 32'd0);
    @(negedge clk);
    bclk = 1'b0; lrc = 1'b0; #100;
    reset = 1'b0; #100;
    v0 = valid_cnt;
    send_frame(16'h0F0F, 16'hF0F0, 99, 10, 16'hC3C3, 16'h3C3C, 99, rx);
    #200;
    check("t5_dac", {dac_data_l, dac_data_r}, 32'h0F0FF0F0);
    check("t5_valid", valid_cnt - v0, 1);
    check("t5_dout_hold_cleared", rx, 32'd0);
    send_frame(16'h0000, 16'hFFFF, 99, 99, '0, '0, 99, rx);
    #200;
    check("t5_load_next_frame", rx, 32'hC3C33C3C);
    check("t5_dac_b", {dac_data_l, dac_data_r}, 32'h0000FFFF);

`ifdef AUDIO_SLAVE_LOOPBACK_EN
    // Test 6: frame N echoed during frame N+1
    loopback = 1'b1;
    send_frame(16'h1111, 16'h2222, 99, 99, '0, '0, 99, rx);
    #200;
    check("t6_first", rx, 32'hC3C33C3C);
    send_frame(16'h3333, 16'h4444, 99, 99, '0, '0, 99, rx);
    #200;
    check("t6_loop", rx, 32'h11112222);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
